// File: rtl/softermax_seq_if.sv
// Element stream in, softmax partial result out.
// Shared by the softermax_seq core and whatever drives it.
`ifndef DATA_SIZE
`define DATA_SIZE 8
`endif
`ifndef FRAC
`define FRAC 4
`endif
`ifndef LARGE_SIZE
`define LARGE_SIZE 8
`endif

interface softermax_seq_if #(
    parameter int VEC_LEN = 16,
    parameter int ACC_W   = `LARGE_SIZE + 1 + $clog2(VEC_LEN)
) ();
    logic                                in_valid;
    logic                                in_ready;
    logic [`DATA_SIZE-1:0]               in_data;
    logic                                in_last;
    logic                                out_valid;
    logic                                out_ready;
    logic signed [`DATA_SIZE-`FRAC-1:0]  max_out;
    logic [ACC_W-1:0]                    denom_out;
    logic [$clog2(VEC_LEN):0]            count_out;

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, max_out, denom_out, count_out
    );

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, max_out, denom_out, count_out
    );
endinterface

// File: rtl/softermax_seq.sv
// Streaming softmax denominator with running integer max
// and rescale-on-new-max, using an external Pow2 unit.
`ifndef DATA_SIZE
`define DATA_SIZE 8
`endif
`ifndef FRAC
`define FRAC 4
`endif
`ifndef LARGE_SIZE
`define LARGE_SIZE 8
`endif

module softermax_seq #(
    parameter int VEC_LEN = 16,
    parameter int ACC_W   = `LARGE_SIZE + 1 + $clog2(VEC_LEN)
) (
    input  logic                               clk,
    input  logic                               rst,
    softermax_seq_if.slave                     s,
    output logic signed [`DATA_SIZE-`FRAC-1:0] pow2_max,
    output logic [`DATA_SIZE-1:0]              pow2_x,
    input  logic [`LARGE_SIZE:0]               pow2_res
);
    localparam int DW = `DATA_SIZE;
    localparam int IW = `DATA_SIZE - `FRAC;
    localparam int CW = $clog2(VEC_LEN) + 1;

    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    state_t               state_q, state_d;
    logic signed [IW-1:0] m_q, xi, m_new, pm_q;
    logic [ACC_W-1:0]     d_q, d_new, d_shift;
    logic [CW-1:0]        cnt_q, cnt_new;
    logic [DW-1:0]        px_q;
    logic [IW:0]          diff;
    logic [ACC_W:0]       sum;
    logic                 rdy, acc, first, fin, clr;

    assign rdy     = (state_q != DONE);
    assign acc     = s.in_valid & rdy;
    assign first   = (state_q == IDLE);
    assign cnt_new = cnt_q + 1'b1;
    assign fin     = s.in_last | (cnt_new == CW'(VEC_LEN));

    assign xi    = s.in_data[DW-1:`FRAC];
    assign m_new = (first || xi > m_q) ? xi : m_q;
    assign diff  = {m_new[IW-1], m_new} - {m_q[IW-1], m_q};

    // Old sum is rescaled to the new max; huge shifts flush to zero.
    always_comb begin
        d_shift = '0;
        if (!first && (32'(diff) < ACC_W))
            d_shift = d_q >> diff;
    end

    assign sum   = {1'b0, d_shift} + (ACC_W+1)'(pow2_res);
    assign d_new = sum[ACC_W] ? '1 : sum[ACC_W-1:0];

    assign pow2_x   = acc ? s.in_data : px_q;
    assign pow2_max = acc ? m_new : pm_q;

    assign s.in_ready  = rdy;
    assign s.max_out   = m_q;
    assign s.denom_out = d_q;
    assign s.count_out = cnt_q;

    always_comb begin
        state_d     = state_q;
        s.out_valid = 1'b0;
        clr         = 1'b0;
        unique case (state_q)
            IDLE, ACCUM: begin
                if (acc)
                    state_d = fin ? DONE : ACCUM;
            end
            DONE: begin
                s.out_valid = 1'b1;
                if (s.out_ready) begin
                    state_d = IDLE;
                    clr     = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            m_q   <= {1'b1, {(IW-1){1'b0}}};
            d_q   <= '0;
            cnt_q <= '0;
        end else if (acc) begin
            m_q   <= m_new;
            d_q   <= d_new;
            cnt_q <= cnt_new;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            px_q <= '0;
            pm_q <= '0;
        end else if (acc) begin
            px_q <= s.in_data;
            pm_q <= m_new;
        end
    end
endmodule
